// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin front end for a shared parallel-to-serial
// converter. One word is issued per slot as a single-cycle ser_valid pulse
// (zero-latency accept); further issues are held off while the word shifts
// out and for GAP guard cycles afterwards.
module p2s_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int GAP   = 0,
  localparam int SW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   ser_busy,
  output logic                   ser_valid,
  output logic [WIDTH-1:0]       ser_data,
  output logic                   line_active,
  output logic [SW-1:0]          line_src,
  output logic [15:0]            words_sent
);

  // Counter covers both the shift phase (1..WIDTH-1) and the gap phase (1..GAP).
  localparam int CW = $clog2(WIDTH + GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   ptr_q;
  logic [SW-1:0]   src_q;
  logic [15:0]     words_q;
  logic [SW:0]     idx;
  logic [SW-1:0]   win;
  logic            found;
  logic            issue;

  // Round-robin scan: first valid requester at or above the pointer, wrapping.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(N_REQ)) idx = idx - (SW+1)'(N_REQ);
      if (!found && req_valid[idx[SW-1:0]]) begin
        found = 1'b1;
        win   = idx[SW-1:0];
      end
    end
  end

  // Issue only from IDLE with the serializer in sync; reset suppresses grants.
  assign issue = (state_q == S_IDLE) && found && !ser_busy && !rst;

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: the issue cycle is bit 0 on the line, SHIFT covers bits
  // 1..WIDTH-1, GAP covers the guard cycles, so IDLE returns at t+WIDTH+GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (WIDTH > 1) begin
            state_d = S_SHIFT;
            cnt_d   = CW'(1);
          end else if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(1);
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: grant/pulse/data are combinational in the issue cycle.
  always_comb begin
    req_ready   = '0;
    ser_valid   = 1'b0;
    ser_data    = '0;
    line_active = !rst && (state_q != S_IDLE);
    line_src    = src_q;
    if (issue) begin
      req_ready[win] = 1'b1;
      ser_valid      = 1'b1;
      ser_data       = req_data[int'(win)*WIDTH +: WIDTH];
      line_active    = 1'b1;
      line_src       = win;
    end
  end

  assign words_sent = words_q;

  // Pointer, owner and word count advance on each issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      src_q   <= '0;
      words_q <= '0;
    end else if (issue) begin
      ptr_q   <= (win == SW'(N_REQ - 1)) ? '0 : win + 1'b1;
      src_q   <= win;
      words_q <= words_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Scoreboard bench for p2s_rr_scheduler. Three instances share one stimulus:
// (WIDTH=8,GAP=0), (WIDTH=8,GAP=3), (WIDTH=1,GAP=0). A slot-level model
// (line free from cycle t+WIDTH+GAP, rotating priority) predicts every
// cycle's outputs; a negedge monitor pops and compares.
module tb_p2s_rr_scheduler;

  localparam int WW [3] = '{8, 8, 1};
  localparam int GG [3] = '{0, 3, 0};

  typedef struct packed {
    logic        chk;
    logic [3:0]  ready;
    logic        sv;
    logic [7:0]  sd;
    logic        la;
    logic [1:0]  ls;
    logic [15:0] ws;
  } exp_t;
  typedef exp_t [2:0] rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic        ser_busy = 1'b0;
  logic [7:0]  wd [4];
  logic [31:0] data8;
  logic [3:0]  data1;
  logic        a5 = 1'b0;

  logic [3:0]  rdy [3];
  logic        sv  [3];
  logic [7:0]  sd  [3];
  logic        la  [3];
  logic [1:0]  ls  [3];
  logic [15:0] ws  [3];
  logic [7:0]  sd_a, sd_b;
  logic        sd_c;

  rec_t rq [$];
  int   vectors = 0;
  int   fails   = 0;

  // model state, one slot per instance
  int          free_at [3];
  int          ptr     [3];
  logic [1:0]  src     [3];
  logic [15:0] words   [3];
  int          cyc = 0;

  assign data8 = {wd[3], wd[2], wd[1], wd[0]};
  assign data1 = {wd[3][0], wd[2][0], wd[1][0], wd[0][0]};
  assign sd[0] = sd_a;
  assign sd[1] = sd_b;
  assign sd[2] = {7'b0, sd_c};

  always #5 clk = ~clk;

  p2s_rr_scheduler #(.WIDTH(8), .N_REQ(4), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(data8),
    .req_ready(rdy[0]), .ser_busy(ser_busy), .ser_valid(sv[0]), .ser_data(sd_a),
    .line_active(la[0]), .line_src(ls[0]), .words_sent(ws[0]));

  p2s_rr_scheduler #(.WIDTH(8), .N_REQ(4), .GAP(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(data8),
    .req_ready(rdy[1]), .ser_busy(ser_busy), .ser_valid(sv[1]), .ser_data(sd_b),
    .line_active(la[1]), .line_src(ls[1]), .words_sent(ws[1]));

  p2s_rr_scheduler #(.WIDTH(1), .N_REQ(4), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(data1),
    .req_ready(rdy[2]), .ser_busy(ser_busy), .ser_valid(sv[2]), .ser_data(sd_c),
    .line_active(la[2]), .line_src(ls[2]), .words_sent(ws[2]));

  task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction for it.
  task automatic do_cycle(input logic [3:0] v, input logic b, input logic r);
    rec_t rec;
    exp_t e;
    logic [1:0] w;
    bit hit;
    @(posedge clk);
    #1;
    req_valid = v;
    ser_busy  = b;
    rst       = r;
    for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
    if (a5) wd[0] = 8'hA5;
    for (int d = 0; d < 3; d++) begin
      e     = '0;
      e.chk = (cyc > 0);
      e.ls  = src[d];
      e.ws  = words[d];
      if (r) begin
        ptr[d]     = 0;
        src[d]     = '0;
        words[d]   = '0;
        free_at[d] = cyc + 1;
      end else if (cyc >= free_at[d] && |v && !b) begin
        w   = '0;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!hit && v[(ptr[d] + k) % 4]) begin
            hit = 1'b1;
            w   = 2'((ptr[d] + k) % 4);
          end
        end
        e.ready    = 4'(1) << w;
        e.sv       = 1'b1;
        e.sd       = (WW[d] == 8) ? wd[w] : {7'b0, wd[w][0]};
        e.la       = 1'b1;
        e.ls       = w;
        free_at[d] = cyc + WW[d] + GG[d];
        ptr[d]     = (int'(w) + 1) % 4;
        src[d]     = w;
        words[d]   = words[d] + 16'd1;
      end else begin
        e.la = (cyc < free_at[d]);
      end
      rec[d] = e;
    end
    rq.push_back(rec);
    cyc++;
  endtask

  // Monitor: compare DUT outputs against the queued prediction each cycle.
  rec_t mr;
  always @(negedge clk) begin
    if (rq.size() != 0) begin
      mr = rq.pop_front();
      for (int d = 0; d < 3; d++) begin
        if (mr[d].chk) begin
          check("req_ready",   d, 32'(rdy[d]), 32'(mr[d].ready));
          check("ser_valid",   d, 32'(sv[d]),  32'(mr[d].sv));
          check("ser_data",    d, 32'(sd[d]),  32'(mr[d].sd));
          check("line_active", d, 32'(la[d]),  32'(mr[d].la));
          check("line_src",    d, 32'(ls[d]),  32'(mr[d].ls));
          check("words_sent",  d, 32'(ws[d]),  32'(mr[d].ws));
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    for (int d = 0; d < 3; d++) begin
      free_at[d] = 0;
      ptr[d]     = 0;
      src[d]     = '0;
      words[d]   = '0;
    end
    for (int i = 0; i < 4; i++) wd[i] = '0;
    repeat (3) do_cycle(4'b0000, 1'b0, 1'b1);
    // single requester, fixed word
    a5 = 1'b1;
    repeat (20) do_cycle(4'b0001, 1'b0, 1'b0);
    a5 = 1'b0;
    // all requesters held
    repeat (45) do_cycle(4'b1111, 1'b0, 1'b0);
    // two sparse requesters
    repeat (30) do_cycle(4'b1010, 1'b0, 1'b0);
    // interlock held in IDLE, then released
    repeat (12) do_cycle(4'b0000, 1'b0, 1'b0);
    repeat (5)  do_cycle(4'b0100, 1'b1, 1'b0);
    repeat (3)  do_cycle(4'b0100, 1'b0, 1'b0);
    // reset mid-word, then req0/req1
    repeat (4)  do_cycle(4'b1111, 1'b0, 1'b0);
    repeat (2)  do_cycle(4'b0011, 1'b0, 1'b1);
    repeat (10) do_cycle(4'b0011, 1'b0, 1'b0);
    // pointer parked past 3, then only req0
    repeat (12) do_cycle(4'b1000, 1'b0, 1'b0);
    repeat (12) do_cycle(4'b0001, 1'b0, 1'b0);
    // randomized traffic with occasional busy and reset
    repeat (3000) begin
      v = 4'($urandom);
      if ($urandom_range(0, 2) == 0) v = 4'(1) << $urandom_range(0, 3);
      do_cycle(v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 399) == 0));
    end
    // long saturated run: the WIDTH=1 instance wraps words_sent
    repeat (65540) do_cycle(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
